aes_round_sequencer: RTL and testbench

//  Iterative AES-128 encryption controller. Accepts one plaintext block over a valid/ready handshake and

---
 rtl/aes_round_sequencer.sv | 130 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 cipher controller: walks an external single-round datapath
// through NR rounds and selects each round key from the expanded-key word bus.
module aes_round_sequencer #(
  parameter int unsigned NR    = 10,
  parameter int unsigned BLK_W = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:BLK_W-1]        in_block,
  input  logic [0:(NR+1)*BLK_W-1] words,
  output logic [0:BLK_W-1]        rnd_state,
  output logic [0:BLK_W-1]        rnd_key,
  output logic                    rnd_final,
  input  logic [0:BLK_W-1]        rnd_result,
  output logic [3:0]              round_num,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:BLK_W-1]        out_block
);

  localparam int unsigned KEY_W     = (NR + 1) * BLK_W;
  localparam int unsigned KEY_IDX_W = $clog2(KEY_W);
  localparam int unsigned RND_W     = 4;
  localparam int unsigned FSM_W     = 2;

  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NR);
  localparam logic [RND_W-1:0] FIRST_RND = RND_W'(1);

  localparam logic [FSM_W-1:0] S_IDLE  = 2'd0;
  localparam logic [FSM_W-1:0] S_ROUND = 2'd1;
  localparam logic [FSM_W-1:0] S_DONE  = 2'd2;

  logic [FSM_W-1:0]     r_fsm;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [0:BLK_W-1]     r_out_block;
  logic [RND_W-1:0]     r_round_num;
  logic [0:BLK_W-1]     r_state;

  logic [FSM_W-1:0]     w_fsm_nxt;
  logic                 w_in_ready_nxt;
  logic                 w_out_valid_nxt;
  logic [0:BLK_W-1]     w_out_block_nxt;
  logic [RND_W-1:0]     w_round_num_nxt;
  logic [0:BLK_W-1]     w_state_nxt;
  logic [KEY_IDX_W-1:0] w_key_base;

  // Next-state and next-output decode
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_out_block_nxt = r_out_block;
    w_round_num_nxt = r_round_num;
    w_state_nxt     = r_state;

    case (r_fsm)
      S_IDLE: begin
        w_in_ready_nxt = 1'b1;
        if (in_valid && r_in_ready) begin
          // Round 0 is a bare AddRoundKey, folded into the load
          w_state_nxt     = in_block ^ words[0:BLK_W-1];
          w_round_num_nxt = FIRST_RND;
          w_in_ready_nxt  = 1'b0;
          w_fsm_nxt       = S_ROUND;
        end
      end

      S_ROUND: begin
        w_state_nxt = rnd_result;
        if (r_round_num == LAST_RND) begin
          w_out_block_nxt = rnd_result;
          w_out_valid_nxt = 1'b1;
          w_round_num_nxt = '0;
          w_fsm_nxt       = S_DONE;
        end else begin
          w_round_num_nxt = RND_W'(r_round_num + FIRST_RND);
        end
      end

      S_DONE: begin
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_fsm_nxt       = S_IDLE;
        end
      end

      default: begin
        w_fsm_nxt       = S_IDLE;
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_round_num_nxt = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_block <= '0;
      r_round_num <= '0;
      r_state     <= '0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_block <= w_out_block_nxt;
      r_round_num <= w_round_num_nxt;
      r_state     <= w_state_nxt;
    end
  end

  // Round key is a pure slice of the word bus; the key is never snapshotted
  assign w_key_base = KEY_IDX_W'(r_round_num) * KEY_IDX_W'(BLK_W);
  assign rnd_key    = words[w_key_base +: BLK_W];
  assign rnd_final  = (r_round_num == LAST_RND);

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_block  = r_out_block;
  assign round_num  = r_round_num;
  assign rnd_state  = r_state;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: models the single-round AES datapath and
// KeyExpansion, then checks sequencing against FIPS-197 known answers.
module tb_aes_round_sequencer;

  localparam int unsigned NR    = 10;
  localparam int unsigned BLK_W = 128;

  localparam logic [0:127] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_X  = 128'hdeadbeefcafef00d0123456789abcdef;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [0:BLK_W-1]        in_block;
  logic [0:(NR+1)*BLK_W-1] words;
  logic [0:BLK_W-1]        rnd_state;
  logic [0:BLK_W-1]        rnd_key;
  logic                    rnd_final;
  logic [0:BLK_W-1]        rnd_result;
  logic [3:0]              round_num;
  logic                    out_valid;
  logic                    out_ready;
  logic [0:BLK_W-1]        out_block;

  logic [7:0] sbox [256];
  int n_checks;
  int n_errors;

  aes_round_sequencer #(.NR(NR), .BLK_W(BLK_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .words      (words),
    .rnd_state  (rnd_state),
    .rnd_key    (rnd_key),
    .rnd_final  (rnd_final),
    .rnd_result (rnd_result),
    .round_num  (round_num),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [0:1407] expand(input logic [0:127] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [0:1407] res;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  // One cipher round: SubBytes, ShiftRows, MixColumns (skipped on final), AddRoundKey
  function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] k,
                                             input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] res;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[8*i +: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r + 4*c] = b[r + 4*((c + r) % 4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = t[i] ^ k[8*i +: 8];
    return res;
  endfunction

  always_comb rnd_result = aes_round(rnd_state, rnd_key, rnd_final);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag);
    int i = 0;
    while (!out_valid && i < 40) begin
      tick();
      i++;
    end
    check(tag, 128'(out_valid), 128'(1));
  endtask

  initial begin
    int          acc [$];
    logic [0:127] outs [$];
    int          cyc;

    n_checks = 0;
    n_errors = 0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    words     = expand(KEY_A);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_block  = '0;
    out_ready = 1'b0;

    // Reset state
    tick();
    check("rst_in_ready",  128'(in_ready),  128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_block", out_block,       128'h0);
    check("rst_round_num", 128'(round_num), 128'(0));
    check("rst_state",     rnd_state,       128'h0);
    check("rst_final",     128'(rnd_final), 128'(0));
    rst = 1'b0;
    tick();
    check("idle_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1 with per-round sequencing
    in_valid = 1'b1;
    in_block = PT_A;
    tick();
    in_valid = 1'b0;
    check("acc_state", rnd_state, PT_A ^ words[0:127]);
    check("acc_in_ready", 128'(in_ready), 128'(0));
    for (int r = 1; r <= 10; r++) begin
      check($sformatf("rnd%0d_num", r),   128'(round_num), 128'(r));
      check($sformatf("rnd%0d_key", r),   rnd_key, words[128*r +: 128]);
      check($sformatf("rnd%0d_final", r), 128'(rnd_final), 128'(r == 10));
      check($sformatf("rnd%0d_ov", r),    128'(out_valid), 128'(0));
      tick();
    end
    check("c1_out_valid", 128'(out_valid), 128'(1));
    check("c1_out_block", out_block, CT_A);
    check("c1_round_num", 128'(round_num), 128'(0));
    check("c1_final",     128'(rnd_final), 128'(0));

    // Backpressure in DONE
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_block", out_block, CT_A);
      check("bp_in_ready",  128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rel_out_valid", 128'(out_valid), 128'(0));
    check("bp_rel_in_ready",  128'(in_ready),  128'(1));

    // Busy rejection: a different block offered mid-encryption is ignored
    in_valid = 1'b1;
    in_block = PT_A;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_block = PT_X;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    wait_out("busy_wait");
    check("busy_out_block", out_block, CT_A);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-operation, then encrypt FIPS-197 B vector under a new key
    in_valid = 1'b1;
    in_block = PT_A;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && round_num != 4'd5; i++) tick();
    check("mid_at_rnd5", 128'(round_num), 128'(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_in_ready",  128'(in_ready),  128'(0));
    check("mid_out_valid", 128'(out_valid), 128'(0));
    check("mid_out_block", out_block,       128'h0);
    check("mid_round_num", 128'(round_num), 128'(0));
    check("mid_state",     rnd_state,       128'h0);
    tick();
    check("mid_rec_in_ready",  128'(in_ready),  128'(1));
    check("mid_rec_out_valid", 128'(out_valid), 128'(0));
    words    = expand(KEY_B);
    in_valid = 1'b1;
    in_block = PT_B;
    tick();
    in_valid = 1'b0;
    wait_out("b_wait");
    check("b_out_block", out_block, CT_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back with both handshakes held high
    words     = expand(KEY_A);
    in_valid  = 1'b1;
    in_block  = PT_A;
    out_ready = 1'b1;
    cyc = 0;
    while (outs.size() < 2 && cyc < 60) begin
      if (in_ready && in_valid) acc.push_back(cyc);
      if (out_valid && out_ready) outs.push_back(out_block);
      check("b2b_excl", 128'(in_ready && out_valid), 128'(0));
      tick();
      cyc++;
      if (acc.size() == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_n_acc", 128'(acc.size()),  128'(2));
    check("b2b_n_out", 128'(outs.size()), 128'(2));
    if (acc.size() == 2) check("b2b_spacing", 128'(acc[1] - acc[0]), 128'(NR + 2));
    if (outs.size() == 2) begin
      check("b2b_ct0", outs[0], CT_A);
      check("b2b_ct1", outs[1], CT_A);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
